// File: rtl/crc_p2_onchip_mem_arb_pkg.sv
// Shared types and constants for the two-requester on-chip RAM arbiter.
package crc_p2_onchip_mem_arb_pkg;

    // Arbiter ownership state: nobody, requester 0, requester 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Requester identity, carried with every read through the tag pipeline.
    typedef logic owner_t;

    localparam owner_t OWNER_R0 = 1'b0;
    localparam owner_t OWNER_R1 = 1'b1;

    // Cycles from read accept to readdatavalid at the requester.
    localparam int RD_LATENCY = 2;

endpackage

// File: rtl/crc_p2_onchip_mem_arb_grant.sv
// Combinational grant / next-state logic for the RAM arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin with MAX_HOLD fairness; the default
// build is fixed priority with r0 always winning.
module crc_p2_onchip_mem_arb_grant
    import crc_p2_onchip_mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  arb_state_t        state,
    input  logic [HOLD_W-1:0] hold_cnt,
    input  owner_t            last_grant,
    input  logic              req0,
    input  logic              req1,
    output logic [1:0]        grant,
    output arb_state_t        next_state
);

`ifdef ARB_ROUND_ROBIN_EN
    logic hold_full;

    assign hold_full = (hold_cnt >= HOLD_W'(MAX_HOLD));

    // Round-robin: owner keeps the RAM until it idles or has used its MAX_HOLD turns while the other waits.
    always_comb begin
        next_state = IDLE;
        case (state)
            OWN0: begin
                if (req0 && !(req1 && hold_full)) next_state = OWN0;
                else if (req1)                    next_state = OWN1;
                else                              next_state = IDLE;
            end
            OWN1: begin
                if (req1 && !(req0 && hold_full)) next_state = OWN1;
                else if (req0)                    next_state = OWN0;
                else                              next_state = IDLE;
            end
            default: begin
                if (req0 && req1) next_state = (last_grant == OWNER_R1) ? OWN0 : OWN1;
                else if (req0)    next_state = OWN0;
                else if (req1)    next_state = OWN1;
                else              next_state = IDLE;
            end
        endcase
    end
`else
    logic unused_ctx;

    // History does not matter under fixed priority, so it is folded away here.
    assign unused_ctx = ^{state, hold_cnt, last_grant};

    // Fixed priority: r0 wins every contest in every state; r1 only gets idle cycles of r0.
    always_comb begin
        next_state = IDLE;
        if (req0)      next_state = OWN0;
        else if (req1) next_state = OWN1;
    end
`endif

    // The owner for the next cycle is also the requester served this cycle.
    assign grant = {next_state == OWN1, next_state == OWN0};

endmodule

// File: rtl/crc_p2_onchip_mem_arbiter.sv
// Two-port Avalon-MM front end for one single-port synchronous RAM.
// Arbitrates r0/r1, issues at most one command per cycle and routes read
// data back to the issuing requester two cycles after accept.
// Build option: ARB_ROUND_ROBIN_EN (round-robin + MAX_HOLD fairness);
// undefined gives fixed priority to r0.
module crc_p2_onchip_mem_arbiter
    import crc_p2_onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   r0_address,
    input  logic [DATA_W/8-1:0] r0_byteenable,
    input  logic                r0_read,
    input  logic                r0_write,
    input  logic [DATA_W-1:0]   r0_writedata,
    output logic                r0_waitrequest,
    output logic [DATA_W-1:0]   r0_readdata,
    output logic                r0_readdatavalid,
    input  logic [ADDR_W-1:0]   r1_address,
    input  logic [DATA_W/8-1:0] r1_byteenable,
    input  logic                r1_read,
    input  logic                r1_write,
    input  logic [DATA_W-1:0]   r1_writedata,
    output logic                r1_waitrequest,
    output logic [DATA_W-1:0]   r1_readdata,
    output logic                r1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic              req0;
    logic              req1;
    arb_state_t        state_q;
    arb_state_t        next_state;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_nxt;
    owner_t            last_q;
    logic [1:0]        grant_raw;
    logic [1:0]        gnt;

    logic              vld_p0;
    owner_t            tag_p0;
    logic              vld_p1;
    owner_t            tag_p1;

    // A simultaneous read+write is illegal; it is served as a write.
    assign req0 = r0_read | r0_write;
    assign req1 = r1_read | r1_write;

    crc_p2_onchip_mem_arb_grant #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_grant (
        .state      (state_q),
        .hold_cnt   (hold_q),
        .last_grant (last_q),
        .req0       (req0),
        .req1       (req1),
        .grant      (grant_raw),
        .next_state (next_state)
    );

    // Nothing is accepted while reset is held.
    assign gnt = reset ? 2'b00 : grant_raw;

    // Consecutive-grant count: restarts on an owner change, saturates at MAX_HOLD.
    always_comb begin
        hold_nxt = hold_q;
        if (next_state == IDLE)            hold_nxt = '0;
        else if (next_state != state_q)    hold_nxt = HOLD_W'(1);
        else if (hold_q < HOLD_W'(MAX_HOLD)) hold_nxt = hold_q + HOLD_W'(1);
    end

    // Arbiter state, hold count and last-served requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= OWNER_R1;
        end else begin
            state_q <= next_state;
            hold_q  <= hold_nxt;
            if (|gnt) last_q <= gnt[1] ? OWNER_R1 : OWNER_R0;
        end
    end

    assign r0_waitrequest = ~gnt[0];
    assign r1_waitrequest = ~gnt[1];
    assign mem_clken      = 1'b1;

    // Stage p0: steer the granted requester's command onto the RAM port.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (gnt[0]) begin
            mem_address    = r0_address;
            mem_byteenable = r0_byteenable;
            mem_writedata  = r0_writedata;
            mem_chipselect = 1'b1;
            mem_write      = r0_write;
        end else if (gnt[1]) begin
            mem_address    = r1_address;
            mem_byteenable = r1_byteenable;
            mem_writedata  = r1_writedata;
            mem_chipselect = 1'b1;
            mem_write      = r1_write;
        end
    end

    assign vld_p0 = mem_chipselect & ~mem_write;
    assign tag_p0 = gnt[1] ? OWNER_R1 : OWNER_R0;

    // Stage p1: owner tag waits while the RAM produces data.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            tag_p1 <= OWNER_R0;
        end else begin
            vld_p1 <= vld_p0;
            tag_p1 <= tag_p0;
        end
    end

    // Stage p2: capture RAM data into the owning requester's response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_readdatavalid <= 1'b0;
            r1_readdatavalid <= 1'b0;
            r0_readdata      <= '0;
            r1_readdata      <= '0;
        end else begin
            r0_readdatavalid <= vld_p1 && (tag_p1 == OWNER_R0);
            r1_readdatavalid <= vld_p1 && (tag_p1 == OWNER_R1);
            if (vld_p1 && (tag_p1 == OWNER_R0)) r0_readdata <= mem_readdata;
            if (vld_p1 && (tag_p1 == OWNER_R1)) r1_readdata <= mem_readdata;
        end
    end

    a_r0_rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(r0_read && r0_write));
    a_r1_rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(r1_read && r1_write));
    a_resp_after_issue: assert property (@(posedge clk) disable iff (reset)
        (r0_readdatavalid || r1_readdatavalid) |-> $past(vld_p0, RD_LATENCY));

endmodule

// File: tb/tb_crc_p2_onchip_mem_arbiter.sv
// Directed bench for crc_p2_onchip_mem_arbiter with a behavioural sync RAM.
module tb_crc_p2_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] r0_address, r1_address;
    logic [3:0]  r0_byteenable, r1_byteenable;
    logic        r0_read, r0_write, r1_read, r1_write;
    logic [31:0] r0_writedata, r1_writedata;
    logic        r0_waitrequest, r1_waitrequest;
    logic [31:0] r0_readdata, r1_readdata;
    logic        r0_readdatavalid, r1_readdatavalid;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    crc_p2_onchip_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .r0_address(r0_address), .r0_byteenable(r0_byteenable), .r0_read(r0_read),
        .r0_write(r0_write), .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
        .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
        .r1_address(r1_address), .r1_byteenable(r1_byteenable), .r1_read(r1_read),
        .r1_write(r1_write), .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
        .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    initial forever #5 clk = ~clk;

    // ---------------- RAM model ----------------
    function automatic logic [31:0] pat(logic [15:0] a);
        return {16'hA5A5, a};
    endfunction

    function automatic logic [31:0] preload(logic [15:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        if (a == 16'h0020) return 32'h00000000;
        return pat(a);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    logic [31:0] wmem  [0:65535];
    logic        wflag [0:65535];
    logic [31:0] cur_word;

    always_comb begin
        cur_word = preload(mem_address);
        if (wflag[mem_address] === 1'b1) cur_word = wmem[mem_address];
    end

    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                wmem[mem_address]  <= merge(cur_word, mem_writedata, mem_byteenable);
                wflag[mem_address] <= 1'b1;
            end else begin
                mem_readdata <= cur_word;
            end
        end
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } req_t;

    typedef struct packed {
        logic        w0, w1, v0, v1, dchk0, dchk1, cs, we;
        logic [15:0] addr;
        logic [31:0] d0, d1;
    } exp_t;

    typedef struct {
        string name;
        logic  rst;
        req_t  q0;
        req_t  q1;
        exp_t  e;
    } vec_t;

    function automatic vec_t nop(string n);
        vec_t v;
        v.name = n; v.rst = 1'b0; v.q0 = '0; v.q1 = '0; v.e = '0;
        v.e.w0 = 1'b1; v.e.w1 = 1'b1;
        return v;
    endfunction

    function automatic vec_t rst_row(string n);
        vec_t v;
        v = nop(n);
        v.rst = 1'b1; v.e.dchk0 = 1'b1; v.e.dchk1 = 1'b1;
        return v;
    endfunction

    function automatic vec_t gnt(vec_t vi, int who, logic [15:0] a, logic we);
        vec_t v;
        v = vi;
        if (who == 0) v.e.w0 = 1'b0; else v.e.w1 = 1'b0;
        v.e.cs = 1'b1; v.e.we = we; v.e.addr = a;
        return v;
    endfunction

    function automatic vec_t rdq(vec_t vi, int who, logic [15:0] a);
        vec_t v; req_t r;
        v = vi; r = '0; r.rd = 1'b1; r.addr = a; r.be = 4'hF;
        if (who == 0) v.q0 = r; else v.q1 = r;
        return v;
    endfunction

    function automatic vec_t rd_issue(vec_t vi, int who, logic [15:0] a);
        return gnt(rdq(vi, who, a), who, a, 1'b0);
    endfunction

    function automatic vec_t wr_issue(vec_t vi, int who, logic [15:0] a, logic [3:0] be, logic [31:0] d);
        vec_t v; req_t r;
        v = vi; r = '0; r.wr = 1'b1; r.addr = a; r.be = be; r.wd = d;
        if (who == 0) v.q0 = r; else v.q1 = r;
        return gnt(v, who, a, 1'b1);
    endfunction

    function automatic vec_t rsp(vec_t vi, int who, logic [31:0] d);
        vec_t v;
        v = vi;
        if (who == 0) begin v.e.v0 = 1'b1; v.e.dchk0 = 1'b1; v.e.d0 = d; end
        else          begin v.e.v1 = 1'b1; v.e.dchk1 = 1'b1; v.e.d1 = d; end
        return v;
    endfunction

    task automatic drive(vec_t v);
        reset         = v.rst;
        r0_read       = v.q0.rd;  r0_write     = v.q0.wr;  r0_address = v.q0.addr;
        r0_byteenable = v.q0.be;  r0_writedata = v.q0.wd;
        r1_read       = v.q1.rd;  r1_write     = v.q1.wr;  r1_address = v.q1.addr;
        r1_byteenable = v.q1.be;  r1_writedata = v.q1.wd;
    endtask

    task automatic check_vec(vec_t v);
        chk($sformatf("%s.r0_waitrequest", v.name), r0_waitrequest, v.e.w0);
        chk($sformatf("%s.r1_waitrequest", v.name), r1_waitrequest, v.e.w1);
        chk($sformatf("%s.r0_readdatavalid", v.name), r0_readdatavalid, v.e.v0);
        chk($sformatf("%s.r1_readdatavalid", v.name), r1_readdatavalid, v.e.v1);
        chk($sformatf("%s.mem_chipselect", v.name), mem_chipselect, v.e.cs);
        chk($sformatf("%s.mem_write", v.name), mem_write, v.e.we);
        if (v.e.cs)    chk($sformatf("%s.mem_address", v.name), mem_address, v.e.addr);
        if (v.e.dchk0) chk($sformatf("%s.r0_readdata", v.name), r0_readdata, v.e.d0);
        if (v.e.dchk1) chk($sformatf("%s.r1_readdata", v.name), r1_readdata, v.e.d1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive(nop("rst"));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    vec_t        tbl[$];
    logic        iss_v [0:63];
    logic        iss_o [0:63];
    logic [31:0] iss_d [0:63];
    int          cnt0, cnt1, n0, n1, total, exp_g;

    initial begin
        drive(nop("init"));
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Single read, byte-lane write + readback, write-then-read at top of memory.
        tbl.push_back(rdq(rst_row("reset_state"), 0, 16'h0010));
        tbl.push_back(rd_issue(nop("t1_rd"), 0, 16'h0010));
        tbl.push_back(nop("t1_wait"));
        tbl.push_back(rsp(nop("t1_resp"), 0, 32'hDEADBEEF));
        tbl.push_back(wr_issue(nop("t2_wr"), 1, 16'h0020, 4'b0101, 32'h11223344));
        tbl.push_back(rd_issue(nop("t2_rd"), 1, 16'h0020));
        tbl.push_back(nop("t2_wait"));
        tbl.push_back(rsp(nop("t2_resp"), 1, 32'h00220044));
        tbl.push_back(wr_issue(nop("t6_wr"), 0, 16'hFFFF, 4'hF, 32'hCAFEF00D));
        tbl.push_back(rd_issue(nop("t6_rd"), 1, 16'hFFFF));
        tbl.push_back(rd_issue(nop("t6_rd_wrap"), 0, 16'h0000));
        tbl.push_back(rsp(nop("t6_resp"), 1, 32'hCAFEF00D));
        // Interleaved reads between requesters; responses must follow their owners.
        tbl.push_back(rsp(rd_issue(nop("alt_a"), 0, 16'h0100), 0, pat(16'h0000)));
        tbl.push_back(rd_issue(nop("alt_b"), 1, 16'h0101));
        tbl.push_back(rsp(rd_issue(nop("alt_c"), 0, 16'h0102), 0, pat(16'h0100)));
        tbl.push_back(rsp(nop("alt_d"), 1, pat(16'h0101)));
        tbl.push_back(rsp(nop("alt_e"), 0, pat(16'h0102)));
        // Reset the cycle after a read is accepted: the response is dropped.
        tbl.push_back(rd_issue(nop("t5_rd"), 0, 16'h0010));
        tbl.push_back(rdq(nop("t5_rst"), 1, 16'h0040));
        tbl[$].rst = 1'b1;
        tbl.push_back(rst_row("t5_after"));
        tbl[$].rst = 1'b0;
        // First tie after reset goes to r0; r1 follows once r0 drops.
        tbl.push_back(rd_issue(rdq(nop("tie_a"), 1, 16'h0031), 0, 16'h0030));
        tbl.push_back(rd_issue(nop("tie_b"), 1, 16'h0031));
        tbl.push_back(rsp(nop("tie_c"), 0, pat(16'h0030)));
        tbl.push_back(rsp(nop("tie_d"), 1, pat(16'h0031)));

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            @(negedge clk);
            check_vec(tbl[i]);
        end

        // Both requesters stream reads; Avalon address advances only on accept.
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        n0 = 8; n1 = 8; total = 16;
`else
        n0 = 6; n1 = 3; total = 9;
`endif
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < total + 2; k++) begin
            @(posedge clk); #1;
            r0_read    = (cnt0 < n0);
            r0_address = 16'h0200 + 16'(cnt0);
            r1_read    = (cnt1 < n1);
            r1_address = 16'h0300 + 16'(cnt1);
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (k < 16) ? ((k / 4) % 2) : -1;
`else
            exp_g = (k < 6) ? 0 : ((k < 9) ? 1 : -1);
`endif
            @(negedge clk);
            chk($sformatf("stream%0d.r0_waitrequest", k), r0_waitrequest, exp_g != 0);
            chk($sformatf("stream%0d.r1_waitrequest", k), r1_waitrequest, exp_g != 1);
            iss_v[k] = (exp_g >= 0);
            iss_o[k] = (exp_g == 1);
            iss_d[k] = pat((exp_g == 1) ? r1_address : r0_address);
            if (exp_g == 0) cnt0++;
            else if (exp_g == 1) cnt1++;
            if (k >= 2) begin
                chk($sformatf("stream%0d.r0_readdatavalid", k), r0_readdatavalid,
                    iss_v[k-2] && !iss_o[k-2]);
                chk($sformatf("stream%0d.r1_readdatavalid", k), r1_readdatavalid,
                    iss_v[k-2] && iss_o[k-2]);
                if (iss_v[k-2])
                    chk($sformatf("stream%0d.readdata", k),
                        iss_o[k-2] ? r1_readdata : r0_readdata, iss_d[k-2]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
